// File: rtl/front_panel_led_driver_if.sv
// CPU-side register bus of the front panel LED driver: write strobe/address/data,
// status read strobe and the returned status snapshot.
interface front_panel_led_driver_if;
   logic       led_wr_stb;
   logic [1:0] led_wr_addr;
   logic [7:0] led_wr_data;
   logic       led_status_rd_stb;
   logic [7:0] led_status_reg;

   modport master (
      output led_wr_stb, led_wr_addr, led_wr_data, led_status_rd_stb,
      input  led_status_reg
   );

   modport slave (
      input  led_wr_stb, led_wr_addr, led_wr_data, led_status_rd_stb,
      output led_status_reg
   );
endinterface

// File: rtl/front_panel_led_driver.sv
// Drives two chained 74HC595s on the front panel: serialises committed 16-bit LED
// patterns MSB first, PWM-dims them through OE#, and reports busy/pending/overrun.
module front_panel_led_driver #(
   parameter int CLK_DIV = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   front_panel_led_driver_if.slave   bus,
   output logic                      sr_clk,
   output logic                      sr_data,
   output logic                      sr_latch,
   output logic                      sr_oe_n
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SHIFT_LO = 2'd1;
   localparam logic [1:0] SHIFT_HI = 2'd2;
   localparam logic [1:0] LATCH    = 2'd3;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [1:0]  state;
   logic [14:0] shreg;
   logic [3:0]  bit_cnt;
   logic [7:0]  div_cnt;
   logic [7:0]  shadow_lo;
   logic [15:0] pending_data;
   logic        pending;
   logic        overrun;
   logic [7:0]  brightness;
   logic [7:0]  pwm_cnt;

   logic busy;
   logic commit;
   logic consume;
   logic div_done;

   assign busy     = (state != IDLE);
   assign commit   = bus.led_wr_stb && (bus.led_wr_addr == 2'd1);
   assign consume  = (state == IDLE) && pending;
   assign div_done = (div_cnt == DIV_LAST);

   // A commit that lands on the consume cycle simply queues behind the frame
   // being taken, so only a commit over an unconsumed frame counts as overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_lo          <= 8'h00;
         pending_data       <= 16'h0000;
         pending            <= 1'b0;
         overrun            <= 1'b0;
         brightness         <= 8'hFF;
         bus.led_status_reg <= 8'h00;
      end else begin
         if (bus.led_wr_stb && (bus.led_wr_addr == 2'd0))
            shadow_lo <= bus.led_wr_data;
         if (bus.led_wr_stb && (bus.led_wr_addr == 2'd2))
            brightness <= bus.led_wr_data;

         if (commit) begin
            pending_data <= {bus.led_wr_data, shadow_lo};
            pending      <= 1'b1;
         end else if (consume) begin
            pending <= 1'b0;
         end

         if (commit && pending && !consume)
            overrun <= 1'b1;
         else if (bus.led_status_rd_stb)
            overrun <= 1'b0;

         if (bus.led_status_rd_stb)
            bus.led_status_reg <= {5'b00000, overrun, pending, busy};
      end
   end

   // Free-running PWM; OE# is registered so it trails pwm_cnt by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt <= 8'h00;
         sr_oe_n <= 1'b1;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         sr_oe_n <= ~(pwm_cnt < brightness);
      end
   end

   // Each bit gets a full CLK_DIV low phase with data already set up, then a
   // CLK_DIV high phase; the latch follows only after the last high phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= 15'h0000;
         bit_cnt  <= 4'd0;
         div_cnt  <= 8'd0;
         sr_clk   <= 1'b0;
         sr_data  <= 1'b0;
         sr_latch <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pending) begin
                  shreg   <= pending_data[14:0];
                  sr_data <= pending_data[15];
                  bit_cnt <= 4'd15;
                  div_cnt <= 8'd0;
                  sr_clk  <= 1'b0;
                  state   <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (div_done) begin
                  div_cnt <= 8'd0;
                  sr_clk  <= 1'b1;
                  state   <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            SHIFT_HI: begin
               if (div_done) begin
                  div_cnt <= 8'd0;
                  sr_clk  <= 1'b0;
                  if (bit_cnt != 4'd0) begin
                     bit_cnt <= bit_cnt - 4'd1;
                     sr_data <= shreg[14];
                     shreg   <= {shreg[13:0], 1'b0};
                     state   <= SHIFT_LO;
                  end else begin
                     sr_data  <= 1'b0;
                     sr_latch <= 1'b1;
                     state    <= LATCH;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            LATCH: begin
               if (div_done) begin
                  div_cnt  <= 8'd0;
                  sr_latch <= 1'b0;
                  state    <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
